// File: rtl/syscall_pkg.sv
// Shared types and constants for the SYSCALL sequencer: FSM states, service codes, funct field.
package syscall_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDispatch,
    StHex,
    StChar,
    StStr,
    StDone,
    StHalt
  } state_e;

  localparam logic [31:0] SvcPrintInt  = 32'd1;
  localparam logic [31:0] SvcPrintStr  = 32'd4;
  localparam logic [31:0] SvcExit      = 32'd10;
  localparam logic [31:0] SvcPrintChar = 32'd11;

  localparam logic [5:0] FunctSyscall = 6'h0C;

  // Little-endian byte lane of a memory word.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/hex_ascii.sv
// Converts one 4-bit nibble to its uppercase ASCII hex digit (0-9, A-F).
module hex_ascii (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = 8'h30 + {4'h0, nibble_i};
    end else begin
      ascii_o = 8'h37 + {4'h0, nibble_i};
    end
  end

endmodule

// File: rtl/syscall_sequencer.sv
// SYSCALL service sequencer: print_int (hex), print_char, print_string and exit.
// Define SYSCALL_STRING_EN to enable print_string and the data-memory port.
module syscall_sequencer
  import syscall_pkg::*;
#(
  parameter int unsigned MAX_STR_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        stall,
  output logic        halted,
  output logic        bad_syscall
);

  state_e      state_q;
  state_e      st;
  logic [31:0] v0_q;
  logic [31:0] a0_q;
  logic [2:0]  hex_cnt_q;
  logic [4:0]  shamt;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic        svc_ok;
  logic        xfer;

  // Outputs decode from IDLE while reset is held so nothing leaks out during reset.
  assign st   = reset ? StIdle : state_q;
  assign xfer = out_valid & out_ready;

  assign shamt  = {~hex_cnt_q, 2'b00};
  assign nibble = a0_q[shamt +: 4];

  hex_ascii u_hex_ascii (
    .nibble_i (nibble),
    .ascii_o  (hex_char)
  );

`ifdef SYSCALL_STRING_EN
  localparam int unsigned CntW = $clog2(MAX_STR_LEN + 1);

  logic [31:0]     ptr_q;
  logic [CntW-1:0] str_cnt_q;
  logic [7:0]      str_byte;

  assign str_byte = lane_byte(dmem_rdata, ptr_q[1:0]);
`else
  logic unused_str;
  assign unused_str = ^{dmem_rdata, MAX_STR_LEN};
`endif

  always_comb begin
    case (v0_q)
      SvcPrintInt, SvcPrintChar, SvcExit: svc_ok = 1'b1;
`ifdef SYSCALL_STRING_EN
      SvcPrintStr:                        svc_ok = 1'b1;
`endif
      default:                            svc_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      v0_q      <= '0;
      a0_q      <= '0;
      hex_cnt_q <= '0;
`ifdef SYSCALL_STRING_EN
      ptr_q     <= '0;
      str_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (syscall) begin
            v0_q    <= v0;
            a0_q    <= a0;
            state_q <= StDispatch;
          end
        end
        StDispatch: begin
          hex_cnt_q <= '0;
`ifdef SYSCALL_STRING_EN
          ptr_q     <= a0_q;
          str_cnt_q <= '0;
`endif
          if (!svc_ok) begin
            state_q <= StDone;
          end else begin
            case (v0_q)
              SvcPrintInt:  state_q <= StHex;
              SvcPrintChar: state_q <= StChar;
              SvcExit:      state_q <= StHalt;
              default:      state_q <= StStr;
            endcase
          end
        end
        StHex: begin
          if (xfer) begin
            hex_cnt_q <= hex_cnt_q + 3'd1;
            if (hex_cnt_q == 3'd7) state_q <= StDone;
          end
        end
        StChar: begin
          if (xfer) state_q <= StDone;
        end
        StStr: begin
`ifdef SYSCALL_STRING_EN
          if (str_byte == 8'h00) begin
            state_q <= StDone;
          end else if (xfer) begin
            ptr_q     <= ptr_q + 32'd1;
            str_cnt_q <= str_cnt_q + 1'b1;
            if (str_cnt_q == CntW'(MAX_STR_LEN - 1)) state_q <= StDone;
          end
`else
          state_q <= StDone;
`endif
        end
        StDone:  state_q <= StIdle;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    stall     = 1'b0;
    dmem_addr = 32'h0;
    case (st)
      StIdle:     stall = syscall;
      StDispatch: stall = 1'b1;
      StHex: begin
        stall     = 1'b1;
        out_valid = 1'b1;
        out_data  = hex_char;
      end
      StChar: begin
        stall     = 1'b1;
        out_valid = 1'b1;
        out_data  = a0_q[7:0];
      end
      StStr: begin
        stall     = 1'b1;
`ifdef SYSCALL_STRING_EN
        out_valid = |str_byte;
        out_data  = str_byte;
        dmem_addr = {ptr_q[31:2], 2'b00};
`endif
      end
      StHalt:     stall = 1'b1;
      default:    stall = 1'b0;
    endcase
  end

  assign halted      = (st == StHalt);
  assign bad_syscall = (st == StDispatch) & ~svc_ok;

endmodule

// File: tb/tb_syscall_sequencer.sv
// Self-checking bench for syscall_sequencer: directed plus randomized service calls checked
// against a byte-level reference model; adapts to the SYSCALL_STRING_EN build option.
module tb_syscall_sequencer;

  localparam int unsigned MaxLen = 4;
  localparam logic [31:0] Base   = 32'h1001_0000;
`ifdef SYSCALL_STRING_EN
  localparam bit StrEn = 1'b1;
`else
  localparam bit StrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        stall;
  logic        halted;
  logic        bad_syscall;

  logic [7:0]  mem [64];
  logic [31:0] word_off;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  bit         exp_term;
  bit         exp_ok;

  syscall_sequencer #(
    .MAX_STR_LEN (MaxLen)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .syscall     (syscall),
    .v0          (v0),
    .a0          (a0),
    .dmem_addr   (dmem_addr),
    .dmem_rdata  (dmem_rdata),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .stall       (stall),
    .halted      (halted),
    .bad_syscall (bad_syscall)
  );

  always #5 clk = ~clk;

  // Combinational little-endian memory over a 64-byte window at Base.
  assign word_off   = dmem_addr - Base;
  assign dmem_rdata = (word_off < 32'd64) ?
      {mem[word_off[5:0] + 6'd3], mem[word_off[5:0] + 6'd2],
       mem[word_off[5:0] + 6'd1], mem[word_off[5:0]]} : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - Base;
    return (off < 32'd64) ? mem[off[5:0]] : 8'h00;
  endfunction

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return cyc[0];
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference model: the byte stream each service should produce.
  function automatic void build_expect(input logic [31:0] sv0, input logic [31:0] sa0);
    exp_q.delete();
    exp_term = 1'b0;
    exp_ok   = 1'b1;
    if (sv0 == 32'd1) begin
      for (int i = 0; i < 8; i++) begin
        logic [3:0] d;
        d = 4'(sa0 >> (28 - 4 * i));
        exp_q.push_back(d < 4'd10 ? 8'h30 + 8'(d) : 8'h41 + 8'(d) - 8'd10);
      end
    end else if (sv0 == 32'd11) begin
      exp_q.push_back(sa0[7:0]);
    end else if (sv0 == 32'd4 && StrEn) begin
      for (int i = 0; i < int'(MaxLen); i++) begin
        logic [7:0] b;
        b = mem_byte(sa0 + 32'(i));
        if (b == 8'h00) begin
          exp_term = 1'b1;
          break;
        end
        exp_q.push_back(b);
      end
    end else if (sv0 != 32'd10) begin
      exp_ok = 1'b0;
    end
  endfunction

  task automatic run_call(input logic [31:0] sv0, input logic [31:0] sa0, input int rmode,
                          input string tag);
    int          done_cyc;
    int          bads;
    logic        hold;
    logic [7:0]  hold_data;
    logic [31:0] ptr;
    logic [31:0] exp_addr;
    bit          is_str;
    build_expect(sv0, sa0);
    is_str    = StrEn && (sv0 == 32'd4);
    got.delete();
    done_cyc  = -1;
    bads      = 0;
    hold      = 1'b0;
    hold_data = 8'h00;
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        syscall = 1'b1;
        v0      = sv0;
        a0      = sa0;
      end else begin
        syscall = 1'($urandom_range(0, 1));
        v0      = $urandom;
        a0      = $urandom;
      end
      out_ready = pick_ready(rmode, cyc);
      @(negedge clk);
      if (cyc == 0) chk({tag, " stall_c0"}, 32'(stall), 32'd1);
      else if (!stall) done_cyc = cyc;
      if (hold) begin
        chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " hold_data"}, 32'(out_data), 32'(hold_data));
      end
      bads += int'(bad_syscall);
      ptr      = sa0 + 32'(got.size());
      exp_addr = (is_str && cyc >= 2 && done_cyc < 0) ? {ptr[31:2], 2'b00} : 32'h0;
      chk({tag, " dmem_addr"}, dmem_addr, exp_addr);
      if (cyc < 2 || done_cyc >= 0) chk({tag, " valid_idle"}, 32'(out_valid), 32'd0);
      if (out_valid && out_ready) got.push_back(out_data);
      hold      = out_valid && !out_ready;
      hold_data = out_data;
    end
    chk({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
    if (rmode == 0) chk({tag, " latency"}, 32'(done_cyc), 32'(2 + exp_q.size() + int'(exp_term)));
    chk({tag, " bad_pulses"}, 32'(bads), exp_ok ? 32'd0 : 32'd1);
    chk({tag, " halted"}, 32'(halted), 32'd0);
    chk({tag, " nbytes"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [31:0] sv;
    logic [31:0] sa;
    int          off;
    int          len;
    int          rm;
    reset     = 1'b1;
    syscall   = 1'b0;
    v0        = '0;
    a0        = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst bad", 32'(bad_syscall), 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    @(posedge clk); #1;
    syscall = 1'b1;
    @(negedge clk);
    chk("rst stall_sys", 32'(stall), 32'd1);
    @(posedge clk); #1;
    syscall = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    chk("post_rst stall", 32'(stall), 32'd0);

    // Directed services
    run_call(32'd11, 32'h0000_0041, 0, "char_A");
    run_call(32'd1, 32'h00C0_FFEE, 0, "int_c0ffee");
    run_call(32'd1, 32'h00C0_FFEE, 1, "int_toggle");
    mem[1] = 8'h48;
    mem[2] = 8'h69;
    mem[3] = 8'h21;
    mem[4] = 8'h00;
    run_call(32'd4, Base + 32'd1, 0, "str_hi");
    for (int i = 16; i < 24; i++) mem[i] = 8'h41 + 8'(i - 16);
    run_call(32'd4, Base + 32'd17, 0, "str_unterm");
    run_call(32'd4, Base + 32'd1, 2, "str_hi_rnd");
    run_call(32'd7, 32'h1234_5678, 0, "bad_7");

    // Randomized services
    for (int k = 0; k < 14; k++) begin
      rm = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: begin sv = 32'd1;  sa = $urandom; end
        1: begin sv = 32'd11; sa = $urandom; end
        2: begin
          off = 32 + $urandom_range(0, 3);
          len = $urandom_range(0, 6);
          for (int i = 0; i < len; i++) mem[off + i] = 8'($urandom_range(1, 255));
          mem[off + len] = 8'h00;
          sv = 32'd4;
          sa = Base + 32'(off);
        end
        default: begin
          sv = $urandom;
          if (sv == 32'd1 || sv == 32'd4 || sv == 32'd10 || sv == 32'd11) sv = 32'd7;
          sa = $urandom;
        end
      endcase
      run_call(sv, sa, rm, $sformatf("rnd%0d", k));
    end

    // Exit: halted and stalled until reset
    @(posedge clk); #1;
    syscall   = 1'b1;
    v0        = 32'd10;
    a0        = $urandom;
    out_ready = 1'b1;
    @(negedge clk);
    chk("exit stall_c0", 32'(stall), 32'd1);
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk); #1;
      syscall   = 1'($urandom_range(0, 1));
      v0        = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("exit stall", 32'(stall), 32'd1);
      if (c >= 2) chk("exit halted", 32'(halted), 32'd1);
      chk("exit valid", 32'(out_valid), 32'd0);
      chk("exit bad", 32'(bad_syscall), 32'd0);
    end
    @(posedge clk); #1;
    reset   = 1'b1;
    syscall = 1'b0;
    @(negedge clk);
    chk("exit_rst halted", 32'(halted), 32'd0);
    chk("exit_rst stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("exit_post halted", 32'(halted), 32'd0);
    chk("exit_post stall", 32'(stall), 32'd0);
    run_call(32'd11, 32'h0000_007A, 0, "char_after_exit");

    // Reset during the third HEX byte
    sa = $urandom;
    build_expect(32'd1, sa);
    got.delete();
    @(posedge clk); #1;
    syscall   = 1'b1;
    v0        = 32'd1;
    a0        = sa;
    out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      syscall = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("midrst valid", 32'(out_valid), 32'd0);
      chk("midrst stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
    end
    chk("midrst nbytes", 32'(got.size()), 32'd2);
    for (int i = 0; i < 2 && i < got.size(); i++)
      chk($sformatf("midrst byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    run_call(32'd1, 32'hDEAD_BEEF, 2, "int_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
